// File: rtl/avg_accum_ctrl.sv
// avg_accum_ctrl
//   Accumulates unsigned samples into a window, then asks an external divider
//   for the average. The window closes after WINDOW samples or early on flush.
//   The result is held until downstream takes it, and then the next window
//   starts.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   s_valid/s_ready/s_data  sample input handshake
//   flush                 close the current window early (ACCUM only)
//   div_start/div_a/div_b divide request: one-cycle pulse, sum and count
//   div_done/div_valid/div_dbz/div_q  divider response
//   m_valid/m_ready       result output handshake
//   m_avg/m_count/m_err   floor average, sample count, empty-window error
//
// State table
//   ACCUM | collecting samples, s_ready high
//   REQ   | div_start pulse, request operands presented
//   WAIT  | waiting for the divider's done pulse
//   OUT   | result presented, waiting for m_ready
module avg_accum_ctrl #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4,
  parameter int WINDOW = 8,
  parameter int SUM_W  = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              flush,
  output logic              div_start,
  output logic [SUM_W-1:0]  div_a,
  output logic [SUM_W-1:0]  div_b,
  input  logic              div_done,
  input  logic              div_valid,
  input  logic              div_dbz,
  input  logic [SUM_W-1:0]  div_q,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_avg,
  output logic [CNT_W-1:0]  m_count,
  output logic              m_err
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WINDOW);

  state_e              state_q;
  logic [SUM_W-1:0]    sum_q;
  logic [SUM_W-1:0]    sum_d;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic                div_start_q;
  logic [SUM_W-1:0]    div_a_q;
  logic [SUM_W-1:0]    div_b_q;
  logic                m_valid_q;
  logic [DATA_W-1:0]   m_avg_q;
  logic [CNT_W-1:0]    m_count_q;
  logic                m_err_q;
  logic                accept;
  logic                close_win;
  logic                result_bad;
  logic                unused_q_hi;

  // s_ready is held low for as long as reset is asserted, not just after
  // the first clock edge.
  assign s_ready    = rst_n && (state_q == ACCUM);
  assign accept     = s_valid && s_ready;

  // Sum and count including the sample accepted this cycle, so a flush
  // arriving together with a sample closes the window with that sample in it.
  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    if (accept) begin
      sum_d   = sum_q + SUM_W'(s_data);
      count_d = count_q + 1'b1;
    end
  end

  assign close_win  = (accept && (count_d == WIN_C)) || flush;

  // A done pulse without a valid result is treated like divide-by-zero.
  assign result_bad = div_dbz || !div_valid;

  // The average always fits in DATA_W bits; the upper quotient bits are unused.
  assign unused_q_hi = ^div_q[SUM_W-1:DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      sum_q       <= '0;
      count_q     <= '0;
      div_start_q <= 1'b0;
      div_a_q     <= '0;
      div_b_q     <= '0;
      m_valid_q   <= 1'b0;
      m_avg_q     <= '0;
      m_count_q   <= '0;
      m_err_q     <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          sum_q   <= sum_d;
          count_q <= count_d;
          if (close_win) begin
            state_q     <= REQ;
            div_start_q <= 1'b1;
            div_a_q     <= sum_d;
            div_b_q     <= SUM_W'(count_d);
          end
        end
        REQ: begin
          div_start_q <= 1'b0;
          state_q     <= WAIT;
        end
        WAIT: begin
          if (div_done) begin
            m_valid_q <= 1'b1;
            m_count_q <= count_q;
            m_err_q   <= result_bad;
            m_avg_q   <= result_bad ? '0 : div_q[DATA_W-1:0];
            state_q   <= OUT;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            sum_q     <= '0;
            count_q   <= '0;
            state_q   <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign div_start = div_start_q;
  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign m_valid   = m_valid_q;
  assign m_avg     = m_avg_q;
  assign m_count   = m_count_q;
  assign m_err     = m_err_q;

endmodule

// File: doc/avg_accum_ctrl.md
AVG_ACCUM_CTRL -- requirements
Module: avg_accum_ctrl

Interface
REQ-001 Parameters SHALL be (name, default, meaning): DATA_W, 8, sample width; CNT_W, 4, sample-count width; WINDOW, 8, samples per window (1..2^CNT_W-1); SUM_W, DATA_W+CNT_W, sum/divider width.
REQ-002 Reset SHALL be rst_n, asynchronous, active-low; clock SHALL be clk.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block accepts sample
- s_data  in  DATA_W  unsigned sample
- flush  in  1  close current window early
- div_start  out  1  one-cycle divide request
- div_a  out  SUM_W  dividend (window sum)
- div_b  out  SUM_W  divisor (sample count, zero-extended)
- div_done  in  1  divider complete pulse
- div_valid  in  1  divider result valid
- div_dbz  in  1  divider divide-by-zero flag
- div_q  in  SUM_W  divider quotient
- m_valid  out  1  average result valid
- m_ready  in  1  downstream accepts result
- m_avg  out  DATA_W  window average (floor)
- m_count  out  CNT_W  samples in the window
- m_err  out  1  empty window (count 0)

Function
REQ-004 FSM SHALL have states ACCUM, REQ, WAIT, OUT; reset state ACCUM.
REQ-005 s_ready SHALL be 1 only in ACCUM; accept = s_valid && s_ready.
REQ-006 On accept: sum <= sum + s_data (SUM_W bits, no overflow possible), count <= count + 1.
REQ-007 ACCUM -> REQ when an accept brings count to WINDOW, or when flush=1 in ACCUM.
REQ-008 flush with a simultaneous accept SHALL include that sample in the window.
REQ-009 flush outside ACCUM SHALL be ignored (no effect, not latched).
REQ-010 REQ: div_start=1 for exactly one cycle, div_a=sum, div_b=count; next state WAIT.
REQ-011 div_a/div_b SHALL hold stable from REQ until leaving WAIT; div_start=0 in all other states.
REQ-012 WAIT: on div_done, register m_count=count; if div_dbz then m_err=1, m_avg=0; else m_err=0, m_avg=div_q[DATA_W-1:0]; next state OUT.
REQ-013 div_done with div_valid=0 and div_dbz=0 SHALL be treated as dbz (m_err=1, m_avg=0).
REQ-014 div_done outside WAIT SHALL be ignored.
REQ-015 OUT: m_valid=1; m_avg/m_count/m_err stable while m_valid && !m_ready.
REQ-016 OUT with m_ready=1: clear sum and count, m_valid<=0, return to ACCUM; s_ready=1 the following cycle.
REQ-017 Latency SHALL be: REQ one cycle after window close; m_valid one cycle after div_done.
REQ-018 The block SHALL never issue div_start while a prior request is outstanding (WAIT or OUT).

Reset
REQ-019 On rst_n=0, immediately: state ACCUM, sum=0, count=0, s_ready=0 while in reset, div_start=0, div_a=0, div_b=0, m_valid=0, m_avg=0, m_count=0, m_err=0.
REQ-020 Reset in any state (including WAIT) SHALL abandon the window; a later div_done SHALL be ignored.
REQ-021 First cycle after reset release SHALL show s_ready=1.

Verification
REQ-022 WINDOW=4, samples 10,20,30,41 back-to-back -> div_a=101, div_b=4, one div_start pulse; m_avg=25, m_count=4, m_err=0.
REQ-023 Samples 7,8 then 9 with flush in the same cycle -> div_a=24, div_b=3; m_avg=8, m_count=3.
REQ-024 flush with no samples -> div_b=0; divider dbz -> m_err=1, m_avg=0, m_count=0.
REQ-025 WINDOW=4, four samples of 255 -> div_a=1020; m_avg=255; no overflow.
REQ-026 m_ready held low 5 cycles in OUT -> m_valid, m_avg stable, s_ready=0, no new div_start; m_ready=1 -> ACCUM next cycle, sum=0.
REQ-027 rst_n pulsed low in WAIT, then div_done -> all outputs at reset values, no m_valid; the next window computes correctly.
